if_id_queue: RTL

- Parametrised fetch-to-decode buffer and the successor to the single-register IF/ID stage.
- Holds up to DEPTH fetched instructions, each with its address and interrupt flags, in a circular queue.
- Upstream (fetch) and downstream (decode) are decoupled by a valid/ready handshake; decode stalls and pipeline flushes are supported.
- When the queue is empty, decode sees a NOP bubble.

---
 rtl/if_id_queue_if.sv | 34 +++
 rtl/if_id_queue.sv | 86 ++++++++
 2 files changed

// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for if_id_queue.
// slave  : the queue side (takes fetch inputs, drives decode outputs).
// master : the environment side (drives fetch and control, observes decode).
interface if_id_queue_if #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned INST_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INT_W  = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              in_valid_i;
  logic              in_ready_o;
  logic [INST_W-1:0] inst_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic [INT_W-1:0]  int_flag_i;
  logic              flush_i;
  logic              hold_i;
  logic              out_valid_o;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic [INT_W-1:0]  int_flag_o;
  logic [CNT_W-1:0]  count_o;

  modport slave (
    input  in_valid_i, inst_i, inst_addr_i, int_flag_i, flush_i, hold_i,
    output in_ready_o, out_valid_o, inst_o, inst_addr_o, int_flag_o, count_o
  );

  modport master (
    output in_valid_i, inst_i, inst_addr_i, int_flag_i, flush_i, hold_i,
    input  in_ready_o, out_valid_o, inst_o, inst_addr_o, int_flag_o, count_o
  );
endinterface

// File: rtl/if_id_queue.sv
// Fetch-to-decode circular buffer of DEPTH entries (instruction, address,
// interrupt flags) with valid/ready on the fetch side, hold/flush from decode.
// Ports:
//   clk_i  - rising-edge clock
//   rst_ni - asynchronous active-low reset
//   bus    - if_id_queue_if.slave: fetch inputs, flush/hold, head outputs,
//            in_ready_o / out_valid_o, occupancy count_o
// An empty queue presents a NOP bubble on the head outputs.
module if_id_queue #(
  parameter int unsigned       DEPTH        = 2,
  parameter int unsigned       INST_W       = 32,
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       INT_W        = 8,
  parameter logic [INST_W-1:0] NOP_INST     = INST_W'(32'h0000_0013),
  parameter logic [INT_W-1:0]  INT_NONE_VAL = INT_W'(8'h00)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  if_id_queue_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
    logic [INT_W-1:0]  flags;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  entry_t           wr_entry;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             in_ready;
  logic             out_valid;
  logic             push;
  logic             pop;

  // Handshake derived purely from registered occupancy.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != CNT_W'(0));
  assign push      = bus.in_valid_i & in_ready & ~bus.flush_i;
  assign pop       = out_valid & ~bus.hold_i & ~bus.flush_i;

  assign wr_entry = '{inst: bus.inst_i, addr: bus.inst_addr_i, flags: bus.int_flag_i};

  // Pointer and occupancy state; flush overrides everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // Head is read from the array only, so there is no fetch-to-decode bypass.
  assign head = mem[rd_ptr];

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.inst_o      = out_valid ? head.inst  : NOP_INST;
  assign bus.inst_addr_o = out_valid ? head.addr  : '0;
  assign bus.int_flag_o  = out_valid ? head.flags : INT_NONE_VAL;
  assign bus.count_o     = count;

endmodule
